// File: rtl/hvac_pkg.sv
//------------------------------------------------------------------------------
//  Module   : hvac_pkg
//  Purpose  : Shared state encodings and default timing constants for the
//             HVAC actuator protection stage.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hvac_pkg;

   // Debug-visible state codes; a latched fault is also reported as 2'b11.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_HEAT  = 2'b01,
      ST_COOL  = 2'b10,
      ST_PURGE = 2'b11
   } hvac_state_t;

   localparam int c_cnt_w_def    = 8;
   localparam int c_min_on_def   = 16;
   localparam int c_min_off_def  = 32;
   localparam int c_fan_tail_def = 8;

endpackage

`default_nettype wire

// File: rtl/hvac_actuator_ctrl_lockout_timer.sv
//------------------------------------------------------------------------------
//  Module   : lockout_timer
//  Purpose  : Loadable down-counter that saturates at zero and flags when
//             the protected actuator may be restarted.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lockout_timer #(
   parameter int CNT_W    = 8,
   parameter int LOAD_VAL = 32,
   parameter int RST_VAL  = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic zero
);

   localparam logic [CNT_W-1:0] c_load_val = CNT_W'(LOAD_VAL);
   localparam logic [CNT_W-1:0] c_rst_val  = CNT_W'(RST_VAL);

   logic [CNT_W-1:0] r_count;

   // Reload wins over the running decrement; count parks at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= c_rst_val;
      end else if (load) begin
         r_count <= c_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/hvac_actuator_ctrl.sv
//------------------------------------------------------------------------------
//  Module   : hvac_actuator_ctrl
//  Purpose  : Turns heating/cooling demand into protected heater, compressor
//             and fan drives with minimum on-time, restart lockout, mutual
//             exclusion and fan post-run.
//  Options  : ACT_FAULT_EN - latch a sticky fault when both demands are high.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hvac_actuator_ctrl
   import hvac_pkg::*;
#(
   parameter int MIN_ON   = c_min_on_def,
   parameter int MIN_OFF  = c_min_off_def,
   parameter int FAN_TAIL = c_fan_tail_def,
   parameter int CNT_W    = c_cnt_w_def
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       heating_req,
   input  logic       cooling_req,
   output logic       heater_on,
   output logic       compressor_on,
   output logic       fan_on,
   output logic [1:0] state,
   output logic       fault
);

   // Run counter holds (cycles on - 1), so exit is allowed once it reaches MIN_ON-1.
   localparam logic [CNT_W-1:0] c_on_last   = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] c_tail_last = CNT_W'(FAN_TAIL - 1);

   hvac_state_t      r_state;
   logic [CNT_W-1:0] r_run;
   logic [CNT_W-1:0] r_tail;
   logic             r_heater;
   logic             r_comp;
   logic             r_fan;

   logic w_heat_valid;
   logic w_cool_valid;
   logic w_heat_free;
   logic w_cool_free;
   logic w_heat_exit;
   logic w_cool_exit;
   logic w_fault_trip;
   logic w_faulted;

   // Both demands high at once is contradictory and never counts as a request.
   assign w_heat_valid = heating_req & ~cooling_req;
   assign w_cool_valid = cooling_req & ~heating_req;

   assign w_heat_exit = (r_state == ST_HEAT) & ~w_heat_valid & (r_run >= c_on_last);
   assign w_cool_exit = (r_state == ST_COOL) & ~w_cool_valid & (r_run >= c_on_last);

`ifdef ACT_FAULT_EN
   logic r_fault;

   assign w_fault_trip = heating_req & cooling_req & ~r_fault;
   assign w_faulted    = r_fault;

   // Sticky fault; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fault <= 1'b0;
      end else if (w_fault_trip) begin
         r_fault <= 1'b1;
      end
   end
`else
   assign w_fault_trip = 1'b0;
   assign w_faulted    = 1'b0;
`endif

   // Heater lockout starts clear; compressor starts locked for power-up protection.
   lockout_timer #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (MIN_OFF),
      .RST_VAL  (0)
   ) u_heat_lock (
      .clk  (clk),
      .rst  (rst),
      .load (w_heat_exit | w_fault_trip),
      .zero (w_heat_free)
   );

   lockout_timer #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (MIN_OFF),
      .RST_VAL  (MIN_OFF)
   ) u_cool_lock (
      .clk  (clk),
      .rst  (rst),
      .load (w_cool_exit | w_fault_trip),
      .zero (w_cool_free)
   );

   // Mode sequencing with drives registered alongside the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_run    <= '0;
         r_tail   <= '0;
         r_heater <= 1'b0;
         r_comp   <= 1'b0;
         r_fan    <= 1'b0;
      end else if (w_fault_trip || w_faulted) begin
         // Fault parks on the 2'b11 code with every drive off.
         r_state  <= ST_PURGE;
         r_heater <= 1'b0;
         r_comp   <= 1'b0;
         r_fan    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_heat_valid && w_heat_free) begin
                  r_state  <= ST_HEAT;
                  r_run    <= '0;
                  r_heater <= 1'b1;
                  r_fan    <= 1'b1;
               end else if (w_cool_valid && w_cool_free) begin
                  r_state <= ST_COOL;
                  r_run   <= '0;
                  r_comp  <= 1'b1;
                  r_fan   <= 1'b1;
               end
            end
            ST_HEAT: begin
               if (w_heat_exit) begin
                  r_state  <= ST_PURGE;
                  r_tail   <= '0;
                  r_heater <= 1'b0;
               end else if (r_run != '1) begin
                  r_run <= r_run + 1'b1;
               end
            end
            ST_COOL: begin
               if (w_cool_exit) begin
                  r_state <= ST_PURGE;
                  r_tail  <= '0;
                  r_comp  <= 1'b0;
               end else if (r_run != '1) begin
                  r_run <= r_run + 1'b1;
               end
            end
            ST_PURGE: begin
               if (r_tail >= c_tail_last) begin
                  r_state <= ST_IDLE;
                  r_fan   <= 1'b0;
               end else begin
                  r_tail <= r_tail + 1'b1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_heater <= 1'b0;
               r_comp   <= 1'b0;
               r_fan    <= 1'b0;
            end
         endcase
      end
   end

   assign heater_on     = r_heater;
   assign compressor_on = r_comp;
   assign fan_on        = r_fan;
   assign state         = r_state;
   assign fault         = w_faulted;

endmodule

`default_nettype wire
